fetch_sequencer: RTL

- Consumer side of the program counter: owns the fetch PC, issues instruction-memory read requests, and hands fetched instructions with their PCs to decode.
- Applies branch/jump redirects and guarantees no stale instruction reaches decode.
- Sits between the PC/next-PC logic, the instruction memory port and the decode stage.
- At most one outstanding memory request.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 23 ++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8002_0000;
    localparam int          INSTR_BYTES  = 4;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register with a load enable.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC, issues one imem read at a time and hands
// fetched instructions to decode; redirects squash stale data.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               imem_req_valid,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [WIDTH-1:0]   dec_pc,
    input  logic               dec_ready,
    output logic [WIDTH-1:0]   pc_out
);

    // Sign extension keeps the upper bits set for any WIDTH.
    localparam logic [WIDTH-1:0] PC_MASK = WIDTH'($signed(ALIGN_MASK));
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INSTR_BYTES);

    fetch_state_t     state;
    logic             drop;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_d;
    logic             pc_ld;
    logic             accept;
    logic             resp_hit;

    assign accept   = (state == REQ) && imem_req_ready;
    assign resp_hit = (state == WAIT) && imem_resp_valid;

    always_comb begin
        pc_d  = pc;
        pc_ld = 1'b0;
        if (redirect_valid) begin
            pc_d  = redirect_pc & PC_MASK;
            pc_ld = 1'b1;
        end else if (resp_hit && !drop) begin
            pc_d  = pc + PC_STEP;
            pc_ld = 1'b1;
        end
    end

    fetch_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock (clock),
        .reset (reset),
        .load  (pc_ld),
        .d     (pc_d),
        .q     (pc)
    );

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign pc_out         = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            drop      <= 1'b0;
            dec_valid <= 1'b0;
            dec_instr <= '0;
            dec_pc    <= '0;
        end else if (redirect_valid) begin
            dec_valid <= 1'b0;
            unique case (state)
                REQ: begin
                    // An accepted request still owes us a response.
                    if (accept) begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end else begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state <= REQ;
                        drop  <= 1'b0;
                    end else begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            dec_instr <= imem_resp_data;
                            dec_pc    <= pc;
                            dec_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
